// File: rtl/axi_ram_if.sv
// AXI4 bus bundle between the cache back-end master and the RAM responder.
// The master modport drives requests and write data; the slave modport answers.
interface axi_ram_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 1
);
    logic                  axi_arvalid;
    logic [ADDR_W-1:0]     axi_araddr;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic [AXI_ID_W-1:0]   axi_arid;
    logic                  axi_arready;
    logic                  axi_rvalid;
    logic [DATA_W-1:0]     axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic [AXI_ID_W-1:0]   axi_rid;
    logic                  axi_rready;
    logic                  axi_awvalid;
    logic [ADDR_W-1:0]     axi_awaddr;
    logic [7:0]            axi_awlen;
    logic [2:0]            axi_awsize;
    logic [1:0]            axi_awburst;
    logic [AXI_ID_W-1:0]   axi_awid;
    logic                  axi_awready;
    logic                  axi_wvalid;
    logic [DATA_W-1:0]     axi_wdata;
    logic [DATA_W/8-1:0]   axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_wready;
    logic                  axi_bvalid;
    logic [1:0]            axi_bresp;
    logic [AXI_ID_W-1:0]   axi_bid;
    logic                  axi_bready;

    modport slave (
        input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
        input  axi_rready,
        input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp, axi_bid,
        input  axi_bready
    );

    modport master (
        output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
        output axi_rready,
        output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp, axi_bid,
        output axi_bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: independent read and write FSMs over a dual-port word array.
// Only INCR bursts of full-width beats are serviced; anything else answers SLVERR
// for the whole burst while still honouring the beat count.
// Optional build macro AXI_RAM_STALL_EN: a 16-bit LFSR randomly withholds rvalid/wready.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting read beats until the rlast handshake
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting awlen+1 write beats
// W_RESP | bvalid high until bready
module axi_ram_slave #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int AXI_ID_W   = 1
) (
    input logic     clk,
    input logic     reset,
    axi_ram_if.slave axi
);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_ADDR_W;

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     rdata_q;

    r_state_t              r_state_q, r_state_d;
    logic [MEM_ADDR_W-1:0] r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
    logic                  r_err_q, r_err_d, r_last_q, r_last_d;

    w_state_t              w_state_q, w_state_d;
    logic [MEM_ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
    logic                  w_err_q, w_err_d, w_bad_last_q, w_bad_last_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  rd_en, wr_en, r_fire, w_fire, w_last_beat, stall_ok;
    logic [MEM_ADDR_W-1:0] rd_idx;
    logic                  unused_addr;

    // Address bits outside the word index are deliberately ignored (aliasing).
    assign unused_addr = ^{axi.axi_araddr, axi.axi_awaddr};

`ifdef AXI_RAM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced every cycle.
    always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // LFSR register, reloaded with its seed on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end

    assign stall_ok = lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    assign r_fire      = (r_state_q == R_DATA) && stall_ok && axi.axi_rready;
    assign w_fire      = (w_state_q == W_DATA) && stall_ok && axi.axi_wvalid;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign wr_en       = w_fire && !w_err_q;

    // Read channel next-state: latch the request, then step one word per accepted beat.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_id_d    = r_id_q;
        r_err_d   = r_err_q;
        r_last_d  = r_last_q;
        rd_en     = 1'b0;
        rd_idx    = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi.axi_arvalid) begin
                    r_state_d = R_DATA;
                    r_idx_d   = axi.axi_araddr[BYTE_W+MEM_ADDR_W-1:BYTE_W];
                    r_len_d   = axi.axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_id_d    = axi.axi_arid;
                    r_err_d   = (axi.axi_arburst != 2'b01) || (axi.axi_arsize != 3'(BYTE_W));
                    r_last_d  = (axi.axi_arlen == 8'd0);
                    rd_en     = 1'b1;
                    rd_idx    = axi.axi_araddr[BYTE_W+MEM_ADDR_W-1:BYTE_W];
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_last_d  = 1'b0;
                    end else begin
                        r_idx_d  = r_idx_q + MEM_ADDR_W'(1);
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
                        rd_en    = 1'b1;
                        rd_idx   = r_idx_q + MEM_ADDR_W'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write channel next-state: accept len+1 beats, then hold the response.
    always_comb begin
        w_state_d    = w_state_q;
        w_idx_d      = w_idx_q;
        w_len_d      = w_len_q;
        w_cnt_d      = w_cnt_q;
        w_id_d       = w_id_q;
        w_err_d      = w_err_q;
        w_bad_last_d = w_bad_last_q;
        bresp_d      = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (axi.axi_awvalid) begin
                    w_state_d    = W_DATA;
                    w_idx_d      = axi.axi_awaddr[BYTE_W+MEM_ADDR_W-1:BYTE_W];
                    w_len_d      = axi.axi_awlen;
                    w_cnt_d      = 8'd0;
                    w_id_d       = axi.axi_awid;
                    w_err_d      = (axi.axi_awburst != 2'b01) || (axi.axi_awsize != 3'(BYTE_W));
                    w_bad_last_d = 1'b0;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (axi.axi_wlast != w_last_beat) w_bad_last_d = 1'b1;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                        bresp_d   = (w_err_q || w_bad_last_q || (axi.axi_wlast != w_last_beat))
                                    ? 2'b10 : 2'b00;
                    end else begin
                        w_idx_d = w_idx_q + MEM_ADDR_W'(1);
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi.axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Channel state registers; a reset mid-burst drops the burst without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q    <= R_IDLE;
            r_idx_q      <= '0;
            r_len_q      <= '0;
            r_cnt_q      <= '0;
            r_id_q       <= '0;
            r_err_q      <= 1'b0;
            r_last_q     <= 1'b0;
            w_state_q    <= W_IDLE;
            w_idx_q      <= '0;
            w_len_q      <= '0;
            w_cnt_q      <= '0;
            w_id_q       <= '0;
            w_err_q      <= 1'b0;
            w_bad_last_q <= 1'b0;
            bresp_q      <= 2'b00;
        end else begin
            r_state_q    <= r_state_d;
            r_idx_q      <= r_idx_d;
            r_len_q      <= r_len_d;
            r_cnt_q      <= r_cnt_d;
            r_id_q       <= r_id_d;
            r_err_q      <= r_err_d;
            r_last_q     <= r_last_d;
            w_state_q    <= w_state_d;
            w_idx_q      <= w_idx_d;
            w_len_q      <= w_len_d;
            w_cnt_q      <= w_cnt_d;
            w_id_q       <= w_id_d;
            w_err_q      <= w_err_d;
            w_bad_last_q <= w_bad_last_d;
            bresp_q      <= bresp_d;
        end
    end

    // Dual-port array, never reset; a same-edge read of a written word sees the old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi.axi_wstrb[i]) mem_q[w_idx_q][i*8 +: 8] <= axi.axi_wdata[i*8 +: 8];
            end
        end
        if (rd_en) rdata_q <= mem_q[rd_idx];
    end

    assign axi.axi_arready = (r_state_q == R_IDLE);
    assign axi.axi_rvalid  = (r_state_q == R_DATA) && stall_ok;
    assign axi.axi_rdata   = r_err_q ? '0 : rdata_q;
    assign axi.axi_rresp   = r_err_q ? 2'b10 : 2'b00;
    assign axi.axi_rlast   = r_last_q;
    assign axi.axi_rid     = r_id_q;
    assign axi.axi_awready = (w_state_q == W_IDLE);
    assign axi.axi_wready  = (w_state_q == W_DATA) && stall_ok;
    assign axi.axi_bvalid  = (w_state_q == W_RESP);
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_bid     = w_id_q;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed + randomized bench for axi_ram_slave against a word/byte-mask memory model.
module tb_axi_ram_slave;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_ram_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1)) axi ();

    axi_ram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .AXI_ID_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .axi   (axi)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] ref_mem   [DEPTH];
    logic [31:0] ref_known [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL timeout %s: observed=no handshake expected=handshake within 50 cycles", tag);
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic int word_idx(input logic [31:0] addr, input int beat);
        return (int'(addr[13:2]) + beat) % DEPTH;
    endfunction

    // wlast_at: beat carrying wlast; bwait: cycles bready is held low.
    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int wlast_at, input logic id,
                            input int bwait);
        int t;
        logic err;
        logic [1:0] exp_resp;
        logic [31:0] m;
        int idx;
        err = (burst != 2'b01) || (size != 3'd2);
        exp_resp = (err || (wlast_at != len)) ? 2'b10 : 2'b00;
        @(negedge clk);
        axi.axi_awvalid = 1'b1;
        axi.axi_awaddr  = addr;
        axi.axi_awlen   = len[7:0];
        axi.axi_awsize  = size;
        axi.axi_awburst = burst;
        axi.axi_awid    = id;
        t = 0;
        while (!axi.axi_awready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("awready");
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            axi.axi_wvalid = 1'b1;
            axi.axi_wdata  = wd[b];
            axi.axi_wstrb  = ws[b];
            axi.axi_wlast  = (b == wlast_at);
            t = 0;
            while (!axi.axi_wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("wready");
            @(negedge clk);
        end
        axi.axi_wvalid = 1'b0;
        axi.axi_wlast  = 1'b0;
        chk("bvalid_after_last_beat", axi.axi_bvalid, 1);
        for (int k = 0; k < bwait; k++) begin
            @(negedge clk);
            chk("bvalid_held", axi.axi_bvalid, 1);
        end
        axi.axi_bready = 1'b1;
        chk("bresp", axi.axi_bresp, exp_resp);
        chk("bid", axi.axi_bid, id);
        @(negedge clk);
        axi.axi_bready = 1'b0;
        chk("bvalid_cleared", axi.axi_bvalid, 0);
        chk("awready_back", axi.axi_awready, 1);
        if (!err) begin
            for (int b = 0; b <= len; b++) begin
                idx = word_idx(addr, b);
                m = strb_mask(ws[b]);
                ref_mem[idx]   = (ref_mem[idx] & ~m) | (wd[b] & m);
                ref_known[idx] = ref_known[idx] | m;
            end
        end
    endtask

    // stall_at >= 0: rready low 3 cycles before that beat; -1: random short stalls; -2: none.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input int stall_at);
        int t;
        int k;
        int idx;
        logic err;
        logic [31:0] exp;
        logic [31:0] m;
        err = (burst != 2'b01) || (size != 3'd2);
        @(negedge clk);
        axi.axi_arvalid = 1'b1;
        axi.axi_araddr  = addr;
        axi.axi_arlen   = len[7:0];
        axi.axi_arsize  = size;
        axi.axi_arburst = burst;
        axi.axi_arid    = id;
        t = 0;
        while (!axi.axi_arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("arready");
        @(negedge clk);
        axi.axi_arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            idx = word_idx(addr, b);
            exp = err ? 32'h0 : ref_mem[idx];
            m   = err ? 32'hFFFF_FFFF : ref_known[idx];
            axi.axi_rready = 1'b0;
            t = 0;
            while (!axi.axi_rvalid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("rvalid");
            if (stall_at >= 0)       k = (b == stall_at) ? 3 : 0;
            else if (stall_at == -1) k = ($urandom_range(0, 3) == 0) ? 1 : 0;
            else                     k = 0;
            for (int s = 0; s < k; s++) begin
                @(negedge clk);
                chk("rdata_stable_stalled", axi.axi_rdata & m, exp & m);
                chk("rlast_stable_stalled", axi.axi_rlast, (b == len));
            end
            axi.axi_rready = 1'b1;
            chk("rvalid", axi.axi_rvalid, 1);
            chk("rdata", axi.axi_rdata & m, exp & m);
            chk("rlast", axi.axi_rlast, (b == len));
            chk("rresp", axi.axi_rresp, err ? 2'b10 : 2'b00);
            chk("rid", axi.axi_rid, id);
            @(negedge clk);
        end
        axi.axi_rready = 1'b0;
        chk("rvalid_after_burst", axi.axi_rvalid, 0);
        chk("arready_after_burst", axi.axi_arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int len;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = '0; end
        axi.axi_arvalid = 0; axi.axi_araddr = 0; axi.axi_arlen = 0; axi.axi_arsize = 0;
        axi.axi_arburst = 0; axi.axi_arid = 0; axi.axi_rready = 0;
        axi.axi_awvalid = 0; axi.axi_awaddr = 0; axi.axi_awlen = 0; axi.axi_awsize = 0;
        axi.axi_awburst = 0; axi.axi_awid = 0; axi.axi_wvalid = 0; axi.axi_wdata = 0;
        axi.axi_wstrb = 0; axi.axi_wlast = 0; axi.axi_bready = 0;

        repeat (3) @(negedge clk);
        chk("rst_arready", axi.axi_arready, 1);
        chk("rst_awready", axi.axi_awready, 1);
        chk("rst_rvalid", axi.axi_rvalid, 0);
        chk("rst_rlast", axi.axi_rlast, 0);
        chk("rst_wready", axi.axi_wready, 0);
        chk("rst_bvalid", axi.axi_bvalid, 0);
        chk("rst_rresp", axi.axi_rresp, 0);
        chk("rst_bresp", axi.axi_bresp, 0);
        chk("rst_rid", axi.axi_rid, 0);
        chk("rst_bid", axi.axi_bid, 0);
        reset = 1'b1;
        @(negedge clk);

        // 4-beat INCR write/read at 0x100
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h100, 3, 2'b01, 3'd2, 3, 1'b0, 0);
        do_read(32'h100, 3, 2'b01, 3'd2, 1'b1, -2);

        // Byte-strobe merge
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
        do_write(32'h200, 0, 2'b01, 3'd2, 0, 1'b1, 2);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0011;
        do_write(32'h200, 0, 2'b01, 3'd2, 0, 1'b0, 0);
        do_read(32'h200, 0, 2'b01, 3'd2, 1'b0, -2);
        chk("strb_merge_word", ref_known[128], 32'hFFFF_FFFF);

        // rready low 3 cycles mid-burst
        do_read(32'h100, 3, 2'b01, 3'd2, 1'b0, 2);

        // Wrap of word index at the top of memory, and address aliasing
        wd[0] = 32'hDEAD_0FFF; wd[1] = 32'hBEEF_0000; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h3FFC, 1, 2'b01, 3'd2, 1, 1'b1, 1);
        do_read(32'h3FFC, 1, 2'b01, 3'd2, 1'b1, -2);
        do_read(32'h0000, 0, 2'b01, 3'd2, 1'b0, -2);
        do_read(32'h8000_4000, 0, 2'b01, 3'd2, 1'b0, -2);

        // Error responses
        do_read(32'h100, 3, 2'b10, 3'd2, 1'b1, -1);
        do_read(32'h100, 1, 2'b01, 3'd1, 1'b0, -2);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h180, 3, 2'b01, 3'd2, 1, 1'b0, 0);
        do_read(32'h180, 3, 2'b01, 3'd2, 1'b0, -2);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h100, 3, 2'b10, 3'd2, 3, 1'b1, 0);
        do_read(32'h100, 3, 2'b01, 3'd2, 1'b0, -2);

        // Maximum-length burst
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'(($urandom_range(1, 15))); end
        do_write(32'h2000, 255, 2'b01, 3'd2, 255, 1'b0, 0);
        do_read(32'h2000, 255, 2'b01, 3'd2, 1'b1, -1);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            a = $urandom & 32'hFFFF_FFFC;
            len = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            end
            do_write(a, len, 2'b01, 3'd2, len, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            do_read(a, $urandom_range(0, 15), 2'b01, 3'd2, 1'($urandom_range(0, 1)), -1);
        end

        // Concurrent channels on disjoint addresses
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            do_write(32'h800, 7, 2'b01, 3'd2, 7, 1'b1, 1);
            do_read(32'h2000, 7, 2'b01, 3'd2, 1'b0, -2);
        join

        // Same word read and written on the same edge returns the old value
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        do_write(32'h300, 0, 2'b01, 3'd2, 0, 1'b0, 0);
        wd[0] = 32'h0BAD_BEEF;
        fork
            do_write(32'h300, 0, 2'b01, 3'd2, 0, 1'b0, 0);
            begin
                @(negedge clk);
                do_read(32'h300, 0, 2'b01, 3'd2, 1'b1, -2);
            end
        join
        do_read(32'h300, 0, 2'b01, 3'd2, 1'b0, -2);

        // Reset in the middle of a read burst
        @(negedge clk);
        axi.axi_arvalid = 1'b1; axi.axi_araddr = 32'h100; axi.axi_arlen = 8'd3;
        axi.axi_arsize = 3'd2; axi.axi_arburst = 2'b01; axi.axi_arid = 1'b1;
        @(negedge clk);
        axi.axi_arvalid = 1'b0;
        axi.axi_rready = 1'b1;
        @(negedge clk);
        axi.axi_rready = 1'b0;
        chk("rvalid_before_reset", axi.axi_rvalid, 1);
        reset = 1'b0;
        #1;
        chk("rvalid_in_reset", axi.axi_rvalid, 0);
        chk("rlast_in_reset", axi.axi_rlast, 0);
        chk("arready_in_reset", axi.axi_arready, 1);
        chk("rid_in_reset", axi.axi_rid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(32'h100, 3, 2'b01, 3'd2, 1'b0, -2);
        do_read(32'h200, 0, 2'b01, 3'd2, 1'b1, -2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
